// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: sequences a raster pixel stream into 3x3 windows for the
// Sobel convolution stage, using two line buffers and a row/column FSM.
// Ports:
//   i_clk, i_rstn          clock, async active-low reset
//   i_data, i_valid, i_sof pixel stream in; i_sof marks pixel (0,0)
//   o_data                 9*DW window, slice r*3+c (r=0 oldest row, c=0 oldest column)
//   o_valid, o_eof         window strobe, last-window-of-frame pulse
//   o_busy                 frame in progress
//   o_resync               sof seen mid-frame
module sobel_window_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [DW-1:0]   i_data,
    input  logic            i_valid,
    input  logic            i_sof,
    output logic [9*DW-1:0] o_data,
    output logic            o_valid,
    output logic            o_eof,
    output logic            o_busy,
    output logic            o_resync
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                   state;
    logic [XW-1:0]            x;
    logic [YW-1:0]            y;
    logic [DW-1:0]            lb1 [IMG_W];
    logic [DW-1:0]            lb2 [IMG_W];
    logic [2:0][2:0][DW-1:0]  win;
    logic                     win_v;
    logic                     win_eof;

    logic                     sof_c;
    logic                     take_c;
    logic                     x_wrap_c;
    logic                     emit_c;
    logic                     last_c;
    logic [XW-1:0]            addr_c;
    logic [DW-1:0]            lb1_rd_c;
    logic [DW-1:0]            lb2_rd_c;

    // Accept/emit decode; a sof pixel is always column 0 regardless of x.
    always_comb begin
        sof_c    = i_valid & i_sof;
        take_c   = i_valid & ((state != IDLE) | i_sof);
        x_wrap_c = (x == X_LAST);
        emit_c   = i_valid & ~i_sof & (state == RUN) & (x >= XW'(2));
        last_c   = emit_c & x_wrap_c & (y == Y_LAST);
        addr_c   = sof_c ? '0 : x;
        lb1_rd_c = lb1[addr_c];
        lb2_rd_c = lb2[addr_c];
    end

    // Line buffers: never reset, FILL keeps stale content out of windows.
    always_ff @(posedge i_clk) begin
        if (take_c) begin
            lb2[addr_c] <= lb1_rd_c;
            lb1[addr_c] <= i_data;
        end
    end

    // FSM, counters, window shift registers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            win      <= '0;
            win_v    <= 1'b0;
            win_eof  <= 1'b0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_eof    <= 1'b0;
            o_busy   <= 1'b0;
            o_resync <= 1'b0;
        end else begin
            o_resync <= 1'b0;
            win_v    <= emit_c;
            win_eof  <= last_c;
            o_data   <= win;
            o_valid  <= win_v;
            o_eof    <= win_eof;

            if (take_c) begin
                win[0] <= {lb2_rd_c, win[0][2], win[0][1]};
                win[1] <= {lb1_rd_c, win[1][2], win[1][1]};
                win[2] <= {i_data,   win[2][2], win[2][1]};
            end

            if (sof_c) begin
                // Mid-frame sof: drop the window already staged for output.
                if (state != IDLE) begin
                    o_resync <= 1'b1;
                    o_valid  <= 1'b0;
                    o_eof    <= 1'b0;
                end
                state  <= FILL;
                x      <= XW'(1);
                y      <= '0;
                o_busy <= 1'b1;
            end else if (i_valid && (state != IDLE)) begin
                if (x_wrap_c) begin
                    x <= '0;
                    y <= y + YW'(1);
                    if ((state == FILL) && (y == YW'(1))) begin
                        state <= RUN;
                    end
                    if ((state == RUN) && (y == Y_LAST)) begin
                        state  <= IDLE;
                        y      <= '0;
                        o_busy <= 1'b0;
                    end
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 5x4 frame with ramp pixels 10y+x.
module tb_sobel_window_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = 5;
    localparam int unsigned H  = 4;
    localparam int unsigned WW = 9 * DW;

    logic          i_clk    = 1'b0;
    logic          i_rstn   = 1'b0;
    logic [DW-1:0] i_data   = '0;
    logic          i_valid  = 1'b0;
    logic          i_sof    = 1'b0;
    logic [WW-1:0] o_data;
    logic          o_valid;
    logic          o_eof;
    logic          o_busy;
    logic          o_resync;

    sobel_window_ctrl #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_sof    (i_sof),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_eof    (o_eof),
        .o_busy   (o_busy),
        .o_resync (o_resync)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [WW-1:0] exp_data [$];
    int            exp_cyc  [$];
    logic          exp_eof  [$];
    logic [WW-1:0] got_data [$];
    int            got_cyc  [$];
    logic          got_eof  [$];
    int            n_eof     = 0;
    int            n_resync  = 0;
    int            busy_rise = -1;
    int            busy_fall = -1;
    logic          busy_q    = 1'b0;
    int            sof_cyc   = 0;
    int            last_cyc  = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (o_valid) begin
            got_data.push_back(o_data);
            got_eof.push_back(o_eof);
            got_cyc.push_back(cyc);
        end
        if (o_eof)    n_eof++;
        if (o_resync) n_resync++;
        if (o_busy && !busy_q) busy_rise = cyc;
        if (!o_busy && busy_q) busy_fall = cyc;
        busy_q = o_busy;
    end

    function automatic logic [WW-1:0] ramp_win(input int base, input int x, input int y);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*DW +: DW] = DW'(base + 10*(y-2+r) + (x-2+c));
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            i_sof   = 1'b0;
        end
    endtask

    task automatic send_pixel(input int base, input int x, input int y, input logic sof,
                              input bit exp_en, input int gap);
        @(negedge i_clk);
        i_data  = DW'(base + 10*y + x);
        i_sof   = sof;
        i_valid = 1'b1;
        if (exp_en && x >= 2 && y >= 2) begin
            exp_data.push_back(ramp_win(base, x, y));
            exp_cyc.push_back(cyc + 2);
            exp_eof.push_back((x == W-1) && (y == H-1));
        end
        if (sof) sof_cyc = cyc;
        last_cyc = cyc;
        if (gap > 0) idle(gap);
    endtask

    task automatic send_frame(input int base, input int gap);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                send_pixel(base, x, y, (x == 0 && y == 0), 1'b1, gap);
    endtask

    task automatic compare_windows(input string tag, input int exp_neof, input int exp_nres);
        check({tag, " count"}, WW'(got_data.size()), WW'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check($sformatf("%s win%0d data", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s win%0d cyc",  tag, i), WW'(got_cyc[i]), WW'(exp_cyc[i]));
            check($sformatf("%s win%0d eof",  tag, i), WW'(got_eof[i]), WW'(exp_eof[i]));
        end
        check({tag, " eof pulses"},    WW'(n_eof),    WW'(exp_neof));
        check({tag, " resync pulses"}, WW'(n_resync), WW'(exp_nres));
        exp_data.delete(); exp_cyc.delete(); exp_eof.delete();
        got_data.delete(); got_cyc.delete(); got_eof.delete();
        n_eof    = 0;
        n_resync = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " o_data"},   o_data,          '0);
        check({tag, " o_valid"},  WW'(o_valid),    '0);
        check({tag, " o_eof"},    WW'(o_eof),      '0);
        check({tag, " o_busy"},   WW'(o_busy),     '0);
        check({tag, " o_resync"}, WW'(o_resync),   '0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge i_clk);
        check_outputs_zero("reset");
        i_rstn = 1'b1;
        idle(2);

        // Continuous ramp frame, with busy timing
        send_frame(0, 0);
        idle(4);
        check("s1 first slice0", got_data.size() > 0 ? got_data[0][0*DW +: DW] : '1, WW'(0));
        check("s1 first slice4", got_data.size() > 0 ? got_data[0][4*DW +: DW] : '1, WW'(11));
        check("s1 first slice8", got_data.size() > 0 ? got_data[0][8*DW +: DW] : '1, WW'(22));
        check("s1 busy rise", WW'(busy_rise), WW'(sof_cyc + 1));
        check("s1 busy fall", WW'(busy_fall), WW'(last_cyc + 1));
        compare_windows("s1", 1, 0);

        // Toggling valid
        send_frame(0, 1);
        idle(4);
        compare_windows("s2", 1, 0);

        // Junk without sof while idle, then a frame
        for (int i = 0; i < 4; i++) send_pixel(50, i, 0, 1'b0, 1'b0, 0);
        idle(2);
        check("s3 busy after junk", WW'(o_busy), '0);
        send_frame(0, 0);
        idle(4);
        compare_windows("s3", 1, 0);

        // Frame A aborted by sof at (3,2); the (2,2) window must be suppressed
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < W; x++)
                if (y < 2 || x <= 2) send_pixel(0, x, y, (x == 0 && y == 0), 1'b0, 0);
        send_frame(0, 0);
        idle(4);
        compare_windows("s4", 1, 1);

        // Reset mid-frame at pixel (2,3)
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (y < 3 || x < 2) send_pixel(0, x, y, (x == 0 && y == 0), 1'b1, 0);
        @(negedge i_clk);
        i_data  = DW'(32);
        i_valid = 1'b1;
        i_rstn  = 1'b0;
        #1;
        check_outputs_zero("s5 async");
        i_valid = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            check_outputs_zero("s5 held");
        end
        @(negedge i_clk);
        i_rstn = 1'b1;
        idle(2);
        send_frame(0, 0);
        idle(4);
        compare_windows("s5", 1, 0);

        // Two back-to-back frames, second offset +100
        send_frame(0, 0);
        send_frame(100, 0);
        idle(4);
        check("s6 f2 slice0", got_data.size() > 6 ? got_data[6][0*DW +: DW] : '1, WW'(100));
        compare_windows("s6", 2, 0);
        check("s6 busy end", WW'(o_busy), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
